// File: rtl/sipo_deserializer_pkg.sv
// Shared types and constants for the serial-in / parallel-out deserializer.
package sipo_deserializer_pkg;

  // Widest word the deserializer supports.
  localparam int unsigned MAX_WIDTH = 32;

  // Output holding register state.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Counter width able to hold the values 0..n-1; never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_bit_counter.sv
// Modulo-N bit position counter. Advances only when enable is high and
// flags the bit that completes a word on the wrap output.
module sipo_bit_counter
  import sipo_deserializer_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // High during the cycle whose valid bit is the last of a word.
  assign wrap  = enable && (count_q == LAST);
  assign count = count_q;

  // Next count: hold when idle, wrap from N-1 to 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule : sipo_bit_counter

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a valid/ready output holding
// register. Words completing while the holding register is full and not
// being consumed are dropped.
// Optional feature: define SIPO_OVERFLOW_EN to make 'overflow' a sticky
// word-drop flag; otherwise 'overflow' is tied low.
// Parameters: N word width (2..32), MSB_FIRST bit order (1: first bit -> [N-1]).
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         serial_valid,
  output logic [N-1:0] parallel_out,
  output logic         parallel_valid,
  input  logic         parallel_ready,
  output logic         overflow
);

  localparam int unsigned CW = cnt_width(N);

  logic [CW-1:0] bit_count;
  logic          complete;
  logic          handshake;

  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  out_q,   out_d;
  out_state_e    state_q, state_d;

  sipo_bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (serial_valid),
    .count  (bit_count),
    .wrap   (complete)
  );

  assign handshake      = (state_q == FULL) && parallel_ready;
  assign parallel_out   = out_q;
  assign parallel_valid = (state_q == FULL);

  // Shift the incoming bit in; shift_d is also the completed word on a wrap.
  always_comb begin
    shift_d = shift_q;
    if (serial_valid) begin
      if (MSB_FIRST != 0) shift_d = {shift_q[N-2:0], serial_in};
      else                shift_d = {serial_in, shift_q[N-1:1]};
    end
  end

  // Output FSM: capture on completion when empty or when the held word is
  // being consumed on the same edge; otherwise the new word is dropped.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          out_d   = shift_d;
        end
      end
      FULL: begin
        if (handshake) begin
          if (complete) out_d   = shift_d;
          else          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Shift register, holding register and FSM state with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      out_q   <= '0;
      state_q <= EMPTY;
    end else begin
      shift_q <= shift_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

`ifdef SIPO_OVERFLOW_EN
  logic drop;
  logic overflow_q;

  assign drop     = complete && (state_q == FULL) && !parallel_ready;
  assign overflow = overflow_q;

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (N=4). Two instances
// share the stimulus: one MSB-first, one LSB-first.
module tb_sipo_deserializer;

`ifdef SIPO_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       serial_valid;
  logic       parallel_ready;
  logic [3:0] out_m, out_l;
  logic       valid_m, valid_l;
  logic       ovf_m, ovf_l;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.N(4), .MSB_FIRST(1)) dut_msb (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .serial_valid   (serial_valid),
    .parallel_out   (out_m),
    .parallel_valid (valid_m),
    .parallel_ready (parallel_ready),
    .overflow       (ovf_m)
  );

  sipo_deserializer #(.N(4), .MSB_FIRST(0)) dut_lsb (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .serial_valid   (serial_valid),
    .parallel_out   (out_l),
    .parallel_valid (valid_l),
    .parallel_ready (parallel_ready),
    .overflow       (ovf_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid bit for a single edge.
  task automatic send(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    tick();
    serial_valid = 1'b0;
    serial_in    = 1'b0;
  endtask

  task automatic check_both(input string tag, input logic v,
                            input logic [3:0] wm, input logic [3:0] wl);
    check({tag, " valid_m"}, valid_m, v);
    check({tag, " valid_l"}, valid_l, v);
    check({tag, " out_m"},   out_m,   wm);
    check({tag, " out_l"},   out_l,   wl);
  endtask

  initial begin
    reset          = 1'b0;
    serial_in      = 1'b0;
    serial_valid   = 1'b0;
    parallel_ready = 1'b0;
    #1;
    check_both("reset", 1'b0, 4'h0, 4'h0);
    check("reset ovf_m", ovf_m, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Bits 1,0,1,1 with ready high: MSB 1011, LSB 1101, valid for one cycle.
    parallel_ready = 1'b1;
    send(1'b1);
    check("b2b bit1 valid", valid_m, 1'b0);
    send(1'b0);
    send(1'b1);
    check("bit3 valid", valid_m, 1'b0);
    send(1'b1);
    check_both("w1011", 1'b1, 4'b1011, 4'b1101);
    tick();
    check("w1011 one cycle m", valid_m, 1'b0);
    check("w1011 one cycle l", valid_l, 1'b0);

    // Word A with ready low, then word 5: second word dropped.
    parallel_ready = 1'b0;
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    check_both("hold A", 1'b1, 4'hA, 4'h5);
    check("ovf before drop", ovf_m, 1'b0);
    send(1'b0);
    check("drop bit0 out", out_m, 4'hA);
    send(1'b1);
    send(1'b0);
    check("drop bit2 out", out_m, 4'hA);
    send(1'b1);
    check_both("after drop", 1'b1, 4'hA, 4'h5);
    check("ovf_m after drop", ovf_m, OVF_EN);
    check("ovf_l after drop", ovf_l, OVF_EN);
    parallel_ready = 1'b1;
    tick();
    check("drain valid", valid_m, 1'b0);
    check("ovf sticky", ovf_m, OVF_EN);

    // Words 3 then C; handshake on the edge that completes C.
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    check_both("w3", 1'b1, 4'h3, 4'hC);
    parallel_ready = 1'b0;
    send(1'b1);
    check_both("w3 held b0", 1'b1, 4'h3, 4'hC);
    send(1'b1);
    send(1'b0);
    check_both("w3 held b2", 1'b1, 4'h3, 4'hC);
    parallel_ready = 1'b1;
    send(1'b0);
    check_both("wC no bubble", 1'b1, 4'hC, 4'h3);
    tick();
    check("wC consumed", valid_m, 1'b0);

    // Reset mid-word clears everything at once and discards the partial word.
    send(1'b1);
    send(1'b1);
    reset = 1'b0;
    #2;
    check_both("async reset", 1'b0, 4'h0, 4'h0);
    check("async reset ovf_m", ovf_m, 1'b0);
    check("async reset ovf_l", ovf_l, 1'b0);
    #8;
    reset = 1'b1;
    send(1'b0);
    send(1'b1);
    check("post-reset bit1 valid", valid_m, 1'b0);
    send(1'b1);
    check("post-reset bit2 valid", valid_m, 1'b0);
    send(1'b0);
    check_both("w0110", 1'b1, 4'b0110, 4'b0110);
    tick();
    check("w0110 consumed", valid_m, 1'b0);

    // Bits 1,1,1,1 separated by 3 idle cycles each.
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      if (i < 3) begin
        check($sformatf("gap bit%0d valid", i), valid_m, 1'b0);
        for (int g = 0; g < 3; g++) begin
          tick();
          check($sformatf("gap%0d idle%0d valid", i, g), valid_m, 1'b0);
        end
      end
    end
    check_both("wF", 1'b1, 4'hF, 4'hF);
    tick();
    check("wF consumed", valid_m, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sipo_deserializer

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter N, default 4, SHALL set the word width in bits; legal range is 2..32.
REQ-002 Parameter MSB_FIRST, default 1, SHALL select bit order: 1 means the first received bit lands in parallel_out[N-1]; 0 means it lands in parallel_out[0].
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port serial_in, input, 1 bit: serial data bit.
REQ-006 Port serial_valid, input, 1 bit: serial_in is sampled on this clock edge.
REQ-007 Port parallel_out, output, N bits: the assembled word.
REQ-008 Port parallel_valid, output, 1 bit: parallel_out holds an unconsumed word.
REQ-009 Port parallel_ready, input, 1 bit: the consumer accepts the word when both valid and ready are high.
REQ-010 Port overflow, output, 1 bit: sticky word-drop flag (present only under the macro, see Configuration).

Function
REQ-011 A bit counter (0..N-1) SHALL advance only on edges where serial_valid=1; it SHALL wrap from N-1 to 0.
REQ-012 Each valid bit SHALL be shifted into the shift register in the order set by MSB_FIRST.
REQ-013 The sample at counter N-1 SHALL complete a word; the completed word, including that last bit, SHALL be transferred to the output holding register on the same edge.
REQ-014 Latency: parallel_valid SHALL rise on the cycle after the edge that sampled the Nth bit.
REQ-015 Output FSM states: EMPTY (parallel_valid=0) and FULL (parallel_valid=1).
REQ-016 Transitions:
- EMPTY -> FULL on word completion.
- FULL -> EMPTY on handshake (valid and ready high) with no completion.
- FULL -> FULL on handshake and completion in the same cycle; the new word replaces the old one with no bubble.
REQ-017 parallel_out SHALL hold stable while FULL and not handshaken.
REQ-018 Completion while FULL without a handshake SHALL drop the new word, keep the held word unchanged, and leave the counter wrapping normally.
REQ-019 Idle cycles (serial_valid=0) SHALL freeze the counter and shift register; gaps between bits are legal.
REQ-020 parallel_ready while EMPTY SHALL have no effect.

Reset
REQ-021 While reset=0, the block SHALL clear the counter, shift register, parallel_out, parallel_valid and overflow to 0 immediately, without waiting for clk.
REQ-022 Reset mid-word SHALL discard the partial word; the first valid bit after reset release SHALL be bit 0 of a new word.

Configuration
REQ-023 Macro SIPO_OVERFLOW_EN defined: overflow SHALL set on the cycle after a drop per REQ-018 and SHALL stay high until reset.
REQ-024 SIPO_OVERFLOW_EN undefined: the overflow port SHALL be tied to 0; drop behaviour SHALL be unchanged.

Structure
REQ-025 The shared package SHALL hold the output FSM state enum (EMPTY, FULL) and the maximum-width constant (32).
REQ-026 The bit counter SHALL be implemented as one sub-module, sipo_bit_counter, with ports clk, reset, enable, count and wrap; all other logic SHALL be inline.

Verification (N=4)
REQ-027 MSB_FIRST=1, bits 1,0,1,1 on consecutive cycles, ready=1: parallel_out SHALL be 4'b1011 with parallel_valid high for 1 cycle, starting 1 cycle after the 4th bit.
REQ-028 MSB_FIRST=0, same bits: parallel_out SHALL be 4'b1101.
REQ-029 Word 4'hA with ready=0, then word 4'h5: parallel_out SHALL stay 4'hA and 4'h5 SHALL be dropped; overflow SHALL go to 1 with the macro and stay 0 without it.
REQ-030 Back-to-back words 4'h3 and 4'hC with ready=1 and the handshake coinciding with the second completion: valid SHALL stay high and 4'hC SHALL follow 4'h3 with no gap.
REQ-031 Two bits of a word, then reset=0 for 1 cycle mid-clock, then bits 0,1,1,0: all outputs SHALL be 0 immediately on reset, and the next word SHALL be 4'b0110 (MSB_FIRST=1).
REQ-032 Bits 1,1,1,1 with serial_valid gaps of 3 cycles between bits: the result SHALL be 4'hF, and valid SHALL not assert before the 4th bit.
